// File: rtl/mil_ring_buffer.sv
// mil_ring_buffer
//   FIFO controller that keeps its storage in a window of a shared memory.
//   A producer pushes words through a request/done handshake; a consumer pops
//   them the same way. Words are written through the memory write channel and
//   fetched back through the read channel, whose data may arrive any number of
//   cycles (>=1) after the read strobe.
//
// Parameters
//   DATAW  data word width
//   ADDRW  memory address width
//   BASE   first memory address of the buffer window
//   DEPTH  number of words in the window (any value 2..2^ADDRW-BASE)
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   clear             synchronous flush of the buffer
//   push_request/push_data/push_done   producer handshake
//   pop_request/pop_data/pop_done      consumer handshake
//   mem_wr_addr/mem_wr_data/mem_wr_enable   memory write channel
//   mem_rd_addr/mem_rd_enable/mem_rd_data/mem_rd_ready   memory read channel
//   mem_busy          memory cannot take a new strobe this cycle
//   used/full/empty   fill level and status
module mil_ring_buffer #(
    parameter int DATAW = 16,
    parameter int ADDRW = 8,
    parameter int BASE  = 0,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push_request,
    input  logic [DATAW-1:0] push_data,
    output logic             push_done,
    input  logic             pop_request,
    output logic [DATAW-1:0] pop_data,
    output logic             pop_done,
    output logic [ADDRW-1:0] mem_wr_addr,
    output logic [DATAW-1:0] mem_wr_data,
    output logic             mem_wr_enable,
    output logic [ADDRW-1:0] mem_rd_addr,
    output logic             mem_rd_enable,
    input  logic [DATAW-1:0] mem_rd_data,
    input  logic             mem_rd_ready,
    input  logic             mem_busy,
    output logic [ADDRW:0]   used,
    output logic             full,
    output logic             empty
);

    localparam logic [ADDRW-1:0] L_BASE  = ADDRW'(BASE);
    localparam logic [ADDRW-1:0] L_LAST  = ADDRW'(DEPTH - 1);
    localparam logic [ADDRW:0]   L_DEPTH = (ADDRW + 1)'(DEPTH);

    typedef enum logic {
        W_IDLE,
        W_WRITE
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_WAIT
    } rstate_t;

    wstate_t          r_wstate;
    wstate_t          w_wnext;
    rstate_t          r_rstate;
    rstate_t          w_rnext;

    logic [ADDRW-1:0] r_wr_ptr;
    logic [ADDRW-1:0] r_rd_ptr;
    logic [ADDRW:0]   r_used;
    logic [DATAW-1:0] r_wdata;
    logic [DATAW-1:0] r_pop_data;
    logic             r_pop_done;

    logic             w_wlatch;
    logic             w_rd_accept;

    assign used        = r_used;
    assign full        = (r_used == L_DEPTH);
    assign empty       = (r_used == '0);
    assign pop_data    = r_pop_data;
    assign pop_done    = r_pop_done;
    assign mem_wr_data = r_wdata;

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_wnext       = r_wstate;
        w_wlatch      = 1'b0;
        mem_wr_enable = 1'b0;
        mem_wr_addr   = '0;
        push_done     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (push_request && !full && !mem_busy && !clear) begin
                    w_wnext  = W_WRITE;
                    w_wlatch = 1'b1;
                end
            end
            W_WRITE: begin
                // The strobe always goes out; a flush in this cycle only
                // suppresses the completion and the count change.
                mem_wr_enable = 1'b1;
                mem_wr_addr   = L_BASE + r_wr_ptr;
                push_done     = !clear;
                w_wnext       = W_IDLE;
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_wdata  <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_wstate <= w_wnext;
            if (w_wlatch) begin
                r_wdata <= push_data;
            end
            if (clear) begin
                r_wr_ptr <= '0;
            end else if (push_done) begin
                r_wr_ptr <= (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_rnext       = r_rstate;
        w_rd_accept   = 1'b0;
        mem_rd_enable = 1'b0;
        mem_rd_addr   = '0;
        case (r_rstate)
            R_IDLE: begin
                // While pop_done is high the consumer's request still belongs
                // to the finishing transaction, so it must not start another.
                if (pop_request && !empty && !mem_busy && !clear && !r_pop_done) begin
                    w_rnext = R_REQ;
                end
            end
            R_REQ: begin
                mem_rd_enable = 1'b1;
                mem_rd_addr   = L_BASE + r_rd_ptr;
                w_rnext       = clear ? R_IDLE : R_WAIT;
            end
            R_WAIT: begin
                if (clear) begin
                    w_rnext = R_IDLE;
                end else if (mem_rd_ready) begin
                    w_rd_accept = 1'b1;
                    w_rnext     = R_IDLE;
                end
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate   <= R_IDLE;
            r_rd_ptr   <= '0;
            r_pop_data <= '0;
            r_pop_done <= 1'b0;
        end else begin
            r_rstate   <= w_rnext;
            r_pop_done <= w_rd_accept;
            if (w_rd_accept) begin
                r_pop_data <= mem_rd_data;
            end
            if (clear) begin
                r_rd_ptr <= '0;
            end else if (w_rd_accept) begin
                r_rd_ptr <= (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fill count: moves on the done pulses, so status only reflects
    // completed transfers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_used <= '0;
        end else if (clear) begin
            r_used <= '0;
        end else begin
            r_used <= r_used + (ADDRW + 1)'(push_done) - (ADDRW + 1)'(r_pop_done);
        end
    end

endmodule

// File: tb/tb_mil_ring_buffer.sv
// Directed bench for mil_ring_buffer with a small behavioural memory whose
// read latency is adjustable. Window is BASE=8, DEPTH=4.
module tb_mil_ring_buffer;

    localparam int DATAW = 16;
    localparam int ADDRW = 8;
    localparam int BASE  = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             push_request;
    logic [DATAW-1:0] push_data;
    logic             push_done;
    logic             pop_request;
    logic [DATAW-1:0] pop_data;
    logic             pop_done;
    logic [ADDRW-1:0] mem_wr_addr;
    logic [DATAW-1:0] mem_wr_data;
    logic             mem_wr_enable;
    logic [ADDRW-1:0] mem_rd_addr;
    logic             mem_rd_enable;
    logic [DATAW-1:0] mem_rd_data = '0;
    logic             mem_rd_ready = 1'b0;
    logic             mem_busy;
    logic [ADDRW:0]   used;
    logic             full;
    logic             empty;

    always #5 clk = ~clk;

    mil_ring_buffer #(
        .DATAW(DATAW),
        .ADDRW(ADDRW),
        .BASE (BASE),
        .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .push_request (push_request),
        .push_data    (push_data),
        .push_done    (push_done),
        .pop_request  (pop_request),
        .pop_data     (pop_data),
        .pop_done     (pop_done),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_enable(mem_wr_enable),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_enable(mem_rd_enable),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_ready (mem_rd_ready),
        .mem_busy     (mem_busy),
        .used         (used),
        .full         (full),
        .empty        (empty)
    );

    // Behavioural memory
    logic [DATAW-1:0] mem [256];
    logic [ADDRW-1:0] p_addr = '0;
    int               p_cnt  = 0;
    int               rd_lat = 1;

    always @(posedge clk) begin
        if (mem_wr_enable) mem[mem_wr_addr] <= mem_wr_data;
    end

    always @(posedge clk) begin
        mem_rd_ready <= 1'b0;
        if (mem_rd_enable) begin
            p_addr <= mem_rd_addr;
            if (rd_lat == 1) begin
                mem_rd_ready <= 1'b1;
                mem_rd_data  <= mem[mem_rd_addr];
                p_cnt        <= 0;
            end else begin
                p_cnt <= rd_lat - 1;
            end
        end else if (p_cnt != 0) begin
            p_cnt <= p_cnt - 1;
            if (p_cnt == 1) begin
                mem_rd_ready <= 1'b1;
                mem_rd_data  <= mem[p_addr];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DATAW-1:0] d, output logic [ADDRW-1:0] a,
                             output logic [DATAW-1:0] wd, output logic ok);
        push_request = 1'b1;
        push_data    = d;
        ok = 1'b0;
        a  = '0;
        wd = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (push_done) begin
                a  = mem_wr_addr;
                wd = mem_wr_data;
                ok = mem_wr_enable;
                break;
            end
        end
        push_request = 1'b0;
    endtask

    task automatic pop_word(output logic [DATAW-1:0] d, output logic [ADDRW-1:0] ra,
                            output logic ok);
        pop_request = 1'b1;
        ok = 1'b0;
        d  = '0;
        ra = '0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (mem_rd_enable) ra = mem_rd_addr;
            if (pop_done) begin
                d  = pop_data;
                ok = 1'b1;
                break;
            end
        end
        pop_request = 1'b0;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_used", used, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDRW-1:0] a, ra;
        logic [DATAW-1:0] d, wd;
        logic             ok;
        int               nw, nr, npu, npd, nrdy, pu, pd, wcyc, rcyc;

        rst = 1'b1; clear = 1'b0; push_request = 1'b0; push_data = '0;
        pop_request = 1'b0; mem_busy = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_used", used, 0);
        check("rst_wr_en", mem_wr_enable, 0);
        check("rst_rd_en", mem_rd_enable, 0);
        check("rst_push_done", push_done, 0);
        check("rst_pop_done", pop_done, 0);
        check("rst_pop_data", pop_data, 0);
        rst = 1'b0;
        tick();

        // Basic push/pop ordering and count
        push_word(16'hA5A5, a, wd, ok);
        check("p1_ok", ok, 1); check("p1_addr", a, BASE); check("p1_data", wd, 16'hA5A5);
        tick(); check("p1_used", used, 1); check("p1_empty", empty, 0);
        push_word(16'h1234, a, wd, ok);
        check("p2_ok", ok, 1); check("p2_addr", a, BASE + 1);
        tick(); check("p2_used", used, 2);
        pop_word(d, ra, ok);
        check("q1_ok", ok, 1); check("q1_data", d, 16'hA5A5); check("q1_addr", ra, BASE);
        tick(); check("q1_used", used, 1);
        pop_word(d, ra, ok);
        check("q2_data", d, 16'h1234); check("q2_addr", ra, BASE + 1);
        tick(); check("q2_used", used, 0); check("q2_empty", empty, 1);

        // Simultaneous push_done and pop_done with used=2
        do_clear();
        push_word(16'h2001, a, wd, ok);
        push_word(16'h2002, a, wd, ok);
        tick(); check("sim_pre_used", used, 2);
        pu = -1; pd = -1; d = '0; a = '0;
        pop_request = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) begin push_request = 1'b1; push_data = 16'h2003; end
            tick();
            if (pop_done && pd < 0) begin pd = i + 1; d = pop_data; pop_request = 1'b0; end
            if (push_done && pu < 0) begin pu = i + 1; a = mem_wr_addr; push_request = 1'b0; end
        end
        check("sim_pop_cyc", pd, 3); check("sim_push_cyc", pu, 3);
        check("sim_used", used, 2);
        check("sim_pop_data", d, 16'h2001); check("sim_wr_addr", a, BASE + 2);
        pop_word(d, ra, ok); check("sim_q2", d, 16'h2002); check("sim_q2_addr", ra, BASE + 1);
        pop_word(d, ra, ok); check("sim_q3", d, 16'h2003); check("sim_q3_addr", ra, BASE + 2);
        tick(); check("sim_end_used", used, 0);

        // Full and pointer wrap
        do_clear();
        for (int i = 0; i < 4; i++) begin
            push_word(16'h1001 + 16'(i), a, wd, ok);
            check("fill_ok", ok, 1);
            check("fill_addr", a, BASE + i);
        end
        tick(); check("fill_used", used, 4); check("fill_full", full, 1);
        push_request = 1'b1; push_data = 16'h1005; nw = 0; npu = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_wr_enable) nw++;
            if (push_done) npu++;
        end
        check("full_no_strobe", nw, 0); check("full_no_done", npu, 0);
        pop_word(d, ra, ok);
        push_request = 1'b1;
        check("full_pop_data", d, 16'h1001);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (push_done) begin ok = 1'b1; a = mem_wr_addr; wd = mem_wr_data; break; end
        end
        push_request = 1'b0;
        check("wrap_ok", ok, 1); check("wrap_addr", a, BASE); check("wrap_data", wd, 16'h1005);
        tick(); check("wrap_used", used, 4); check("wrap_full", full, 1);

        // Pop while empty
        do_clear();
        pop_request = 1'b1; nr = 0; npd = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_rd_enable) nr++;
            if (pop_done) npd++;
        end
        check("empty_no_strobe", nr, 0); check("empty_no_done", npd, 0);
        push_word(16'h00FF, a, wd, ok);
        check("empty_push_ok", ok, 1);
        pop_word(d, ra, ok);
        check("empty_pop_ok", ok, 1); check("empty_pop_data", d, 16'h00FF);
        tick(); check("empty_end", empty, 1);

        // mem_busy gating and slow read
        do_clear();
        push_word(16'h3001, a, wd, ok);
        tick();
        mem_busy = 1'b1; push_request = 1'b1; push_data = 16'h3002; pop_request = 1'b1;
        nw = 0; nr = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_wr_enable) nw++;
            if (mem_rd_enable) nr++;
        end
        check("busy_no_wr", nw, 0); check("busy_no_rd", nr, 0);
        rd_lat = 4; mem_busy = 1'b0;
        nw = 0; nr = 0; wcyc = -1; rcyc = -1; pd = -1; d = '0; a = '0; ra = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_wr_enable) begin nw++; wcyc = i; a = mem_wr_addr; end
            if (mem_rd_enable) begin nr++; rcyc = i; ra = mem_rd_addr; end
            if (push_done) push_request = 1'b0;
            if (pop_done) begin pd = i; d = pop_data; pop_request = 1'b0; break; end
        end
        push_request = 1'b0; pop_request = 1'b0;
        check("rel_wr_cnt", nw, 1); check("rel_rd_cnt", nr, 1);
        check("rel_same_cyc", wcyc, rcyc); check("rel_wr_addr", a, BASE + 1);
        check("rel_rd_addr", ra, BASE); check("rel_pop_data", d, 16'h3001);
        check("rel_latency", pd - rcyc, 5);
        rd_lat = 1;
        tick(); check("rel_used", used, 1);

        // clear during WAIT abandons the read
        do_clear();
        for (int i = 0; i < 3; i++) push_word(16'h6001 + 16'(i), a, wd, ok);
        tick(); check("clr_pre_used", used, 3);
        rd_lat = 6; pop_request = 1'b1; ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_rd_enable) begin ok = 1'b1; break; end
        end
        check("clr_req_seen", ok, 1);
        tick();
        pop_request = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_used", used, 0); check("clr_empty", empty, 1);
        npd = 0; nrdy = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pop_done) npd++;
            if (mem_rd_ready) nrdy++;
        end
        check("clr_no_pop_done", npd, 0); check("clr_late_ready", nrdy, 1);
        rd_lat = 1;

        // Async reset during WRITE
        push_word(16'h7001, a, wd, ok);
        tick(); check("ar_pre_used", used, 1);
        push_request = 1'b1; push_data = 16'h7002; ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (push_done) begin ok = mem_wr_enable; break; end
        end
        check("ar_in_write", ok, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_wr_en", mem_wr_enable, 0); check("ar_push_done", push_done, 0);
        check("ar_used", used, 0); check("ar_empty", empty, 1); check("ar_wr_addr", mem_wr_addr, 0);
        push_request = 1'b0;
        #1 rst = 1'b0;
        tick(); check("ar_after_wr_en", mem_wr_enable, 0);
        push_word(16'h7003, a, wd, ok);
        check("ar_restart_ok", ok, 1); check("ar_restart_addr", a, BASE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
